// File: rtl/ftdi_tx_arb_pkg.sv
// Shared types and header-byte layout for the FTDI TX stream arbiter.
// The header carries the granted source id and a continuation flag.
package ftdi_tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } arb_state_e;

   localparam int HDR_CONT_BIT = 7;
   localparam int HDR_ID_LSB   = 0;
   localparam int HDR_ID_W     = 4;

   function automatic logic [7:0] hdr_byte(input logic cont, input logic [HDR_ID_W-1:0] id);
      logic [7:0] b;
      b = '0;
      b[HDR_CONT_BIT] = cont;
      b[HDR_ID_LSB +: HDR_ID_W] = id;
      return b;
   endfunction

endpackage

// File: rtl/ftdi_tx_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first request strictly after ptr,
// wrapping modulo N with an explicit compare-and-reset.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = ptr;
      for (int k = 0; k < N; k++) begin
         if (idx == IDX_W'(N - 1)) begin
            idx = '0;
         end else begin
            idx = idx + IDX_W'(1);
         end
         if (!gnt_vld && req[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx;
         end
      end
   end

endmodule

// File: rtl/ftdi_tx_stream_arbiter.sv
// Packet-granular round-robin arbiter merging N_SRC AXIS byte sources onto one
// FTDI TX stream, with a per-grant burst limit and optional source-id header.
module ftdi_tx_stream_arbiter
   import ftdi_tx_arb_pkg::*;
#(
   parameter int N_SRC     = 4,
   parameter int MAX_BURST = 64,
   parameter bit HEADER_EN = 1'b1
) (
   input  logic               clk,
   input  logic               res,
   input  logic [N_SRC*8-1:0] s_axis_tdata,
   input  logic [N_SRC-1:0]   s_axis_tvalid,
   input  logic [N_SRC-1:0]   s_axis_tlast,
   input  logic [N_SRC-1:0]   s_axis_almost_empty,
   output logic [N_SRC-1:0]   s_axis_tready,
   output logic [7:0]         m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic               m_axis_almost_empty,
   output logic [3:0]         grant_id,
   output logic               busy
);

   localparam int IDX_W = $clog2(N_SRC);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [N_SRC-1:0] cont_q, cont_d;

   logic [IDX_W-1:0] pick_idx;
   logic             pick_vld;
   logic             src_valid, src_last, src_ae;
   logic [7:0]       src_data;
   logic             data_hs;

   rr_pick #(.N(N_SRC), .IDX_W(IDX_W)) u_rr_pick (
      .req     (s_axis_tvalid),
      .ptr     (rr_ptr_q),
      .gnt_idx (pick_idx),
      .gnt_vld (pick_vld)
   );

   always_comb begin
      src_valid = 1'b0;
      src_last  = 1'b0;
      src_ae    = 1'b1;
      src_data  = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_q == IDX_W'(i)) begin
            src_valid = s_axis_tvalid[i];
            src_last  = s_axis_tlast[i];
            src_ae    = s_axis_almost_empty[i];
            src_data  = s_axis_tdata[8*i +: 8];
         end
      end
   end

   assign data_hs = (state_q == DATA) && src_valid && m_axis_tready;

   // rr_ptr resets to the last index so the first search begins at source 0.
   always_ff @(posedge clk) begin
      if (res) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= IDX_W'(N_SRC - 1);
         beat_cnt_q <= '0;
         cont_q     <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         cont_q     <= cont_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      cont_d     = cont_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_d    = pick_idx;
               rr_ptr_d   = pick_idx;
               beat_cnt_d = '0;
               state_d    = HEADER_EN ? HDR : DATA;
            end
         end
         HDR: begin
            if (m_axis_tready) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (data_hs) begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               // tlast wins over the burst limit when both land on the same beat.
               if (src_last) begin
                  cont_d[grant_q] = 1'b0;
                  state_d         = IDLE;
               end else if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                  cont_d[grant_q] = 1'b1;
                  state_d         = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_axis_tready       = '0;
      m_axis_tdata        = '0;
      m_axis_tvalid       = 1'b0;
      m_axis_almost_empty = 1'b1;
      case (state_q)
         HDR: begin
            m_axis_tvalid       = 1'b1;
            m_axis_tdata        = hdr_byte(cont_q[grant_q], HDR_ID_W'(grant_q));
            m_axis_almost_empty = 1'b0;
         end
         DATA: begin
            m_axis_tvalid       = src_valid;
            m_axis_tdata        = src_data;
            m_axis_almost_empty = src_ae;
            for (int i = 0; i < N_SRC; i++) begin
               s_axis_tready[i] = m_axis_tready && (grant_q == IDX_W'(i));
            end
         end
         default: ;
      endcase
   end

   assign grant_id = 4'(grant_q);
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ftdi_tx_stream_arbiter.sv
// Scoreboard bench: source queues feed the arbiter, expected output bytes are queued
// by each directed test and a monitor pops/compares on every output handshake.
module tb_ftdi_tx_stream_arbiter;

   localparam int N_SRC     = 4;
   localparam int MAX_BURST = 64;

   logic               clk = 1'b0;
   logic               res;
   logic [N_SRC*8-1:0] s_axis_tdata;
   logic [N_SRC-1:0]   s_axis_tvalid;
   logic [N_SRC-1:0]   s_axis_tlast;
   logic [N_SRC-1:0]   s_axis_almost_empty;
   logic [N_SRC-1:0]   s_axis_tready;
   logic [7:0]         m_axis_tdata;
   logic               m_axis_tvalid;
   logic               m_axis_tready;
   logic               m_axis_almost_empty;
   logic [3:0]         grant_id;
   logic               busy;

   int checks   = 0;
   int failures = 0;

   logic [8:0]       srcQ [N_SRC][$];
   logic [7:0]       expQ [$];
   logic [N_SRC-1:0] hsVec;

   always #5 clk = ~clk;

   ftdi_tx_stream_arbiter #(
      .N_SRC     (N_SRC),
      .MAX_BURST (MAX_BURST),
      .HEADER_EN (1'b1)
   ) dut (
      .clk                 (clk),
      .res                 (res),
      .s_axis_tdata        (s_axis_tdata),
      .s_axis_tvalid       (s_axis_tvalid),
      .s_axis_tlast        (s_axis_tlast),
      .s_axis_almost_empty (s_axis_almost_empty),
      .s_axis_tready       (s_axis_tready),
      .m_axis_tdata        (m_axis_tdata),
      .m_axis_tvalid       (m_axis_tvalid),
      .m_axis_tready       (m_axis_tready),
      .m_axis_almost_empty (m_axis_almost_empty),
      .grant_id            (grant_id),
      .busy                (busy)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit srcPending();
      for (int i = 0; i < N_SRC; i++) begin
         if (srcQ[i].size() != 0) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic present();
      logic [8:0] head;
      for (int i = 0; i < N_SRC; i++) begin
         if (srcQ[i].size() > 0) begin
            head = srcQ[i][0];
            s_axis_tvalid[i]       = 1'b1;
            s_axis_tdata[8*i +: 8] = head[7:0];
            s_axis_tlast[i]        = head[8];
         end else begin
            s_axis_tvalid[i]       = 1'b0;
            s_axis_tdata[8*i +: 8] = 8'h00;
            s_axis_tlast[i]        = 1'b0;
         end
         s_axis_almost_empty[i] = (srcQ[i].size() <= 2);
      end
   endtask

   task automatic applyStimulus(input int src, input logic [7:0] base, input int len);
      for (int k = 0; k < len; k++) begin
         srcQ[src].push_back({(k == len - 1), 8'(base + 8'(k))});
      end
   endtask

   task automatic expectRun(input logic [7:0] base, input int first, input int count);
      for (int j = 0; j < count; j++) begin
         expQ.push_back(8'(base + 8'(first + j)));
      end
   endtask

   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while ((expQ.size() != 0 || srcPending() || busy) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 2000) begin
         failures++;
         $display("[TB] FAIL drain %s: got %0d pending bytes expected 0", name, expQ.size());
         expQ.delete();
         for (int i = 0; i < N_SRC; i++) srcQ[i].delete();
      end
   endtask

   // Source model: pop a beat from a source whenever it handshook at the previous edge.
   initial begin : driver
      forever begin
         @(negedge clk);
         hsVec = s_axis_tvalid & s_axis_tready;
         @(posedge clk);
         #1;
         for (int i = 0; i < N_SRC; i++) begin
            if (hsVec[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
         end
         present();
      end
   end

   initial begin : monitor
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (!res && m_axis_tvalid && m_axis_tready) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL stream byte: got %0h expected none at %0t", m_axis_tdata, $time);
            end else begin
               e = expQ.pop_front();
               checkOutput("stream byte", m_axis_tdata, e);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      res           = 1'b1;
      m_axis_tready = 1'b1;
      present();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset s_tready", s_axis_tready, 4'b0000);
      checkOutput("reset m_tvalid", m_axis_tvalid, 1'b0);
      checkOutput("reset m_tdata", m_axis_tdata, 8'h00);
      checkOutput("reset grant_id", grant_id, 4'd0);
      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset m_ae", m_axis_almost_empty, 1'b1);
      @(posedge clk);
      #2;
      res = 1'b0;

      // Two simultaneous 3-byte packets: source 0 first, then source 2.
      @(posedge clk);
      #2;
      applyStimulus(0, 8'hA0, 3);
      applyStimulus(2, 8'hC0, 3);
      expQ.push_back(8'h00); expectRun(8'hA0, 0, 3);
      expQ.push_back(8'h02); expectRun(8'hC0, 0, 3);
      present();
      @(negedge clk);
      checkOutput("idle m_tvalid", m_axis_tvalid, 1'b0);
      checkOutput("idle busy", busy, 1'b0);
      @(negedge clk);
      checkOutput("hdr m_tvalid", m_axis_tvalid, 1'b1);
      checkOutput("hdr m_tdata", m_axis_tdata, 8'h00);
      checkOutput("hdr s_tready", s_axis_tready, 4'b0000);
      checkOutput("hdr m_ae", m_axis_almost_empty, 1'b0);
      checkOutput("hdr busy", busy, 1'b1);
      checkOutput("hdr grant_id", grant_id, 4'd0);
      waitDrain("two sources");

      // 70-byte packet is cut after 64 beats and resumed with the continuation flag.
      @(posedge clk);
      #2;
      applyStimulus(1, 8'h00, 70);
      expQ.push_back(8'h01); expectRun(8'h00, 0, 64);
      expQ.push_back(8'h81); expectRun(8'h00, 64, 6);
      present();
      waitDrain("burst cut");

      // tlast on exactly beat 64 ends cleanly, so the next grant header has bit7 clear.
      @(posedge clk);
      #2;
      applyStimulus(1, 8'hC0, 64);
      applyStimulus(1, 8'h20, 2);
      expQ.push_back(8'h01); expectRun(8'hC0, 0, 64);
      expQ.push_back(8'h01); expectRun(8'h20, 0, 2);
      present();
      waitDrain("tlast at limit");

      // Output back-pressure mid-packet must hold the offered byte steady.
      @(posedge clk);
      #2;
      applyStimulus(3, 8'h50, 10);
      expQ.push_back(8'h03); expectRun(8'h50, 0, 10);
      present();
      repeat (4) @(posedge clk);
      #2;
      m_axis_tready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("stall m_tdata", m_axis_tdata, 8'h52);
         checkOutput("stall m_tvalid", m_axis_tvalid, 1'b1);
      end
      checkOutput("stall m_ae", m_axis_almost_empty, 1'b0);
      checkOutput("stall grant_id", grant_id, 4'd3);
      @(posedge clk);
      #2;
      m_axis_tready = 1'b1;
      waitDrain("stall");

      // All four sources with two 1-byte packets each: strict 0,1,2,3 rotation.
      @(posedge clk);
      #2;
      for (int r = 0; r < 2; r++) begin
         for (int s = 0; s < N_SRC; s++) begin
            applyStimulus(s, 8'(8'h60 + 8'(4 * r + s)), 1);
         end
      end
      for (int r = 0; r < 2; r++) begin
         for (int s = 0; s < N_SRC; s++) begin
            expQ.push_back(8'(s));
            expQ.push_back(8'(8'h60 + 8'(4 * r + s)));
         end
      end
      present();
      waitDrain("rotation");

      // Reset while beat 10 of source 2 is offered; that beat is lost at the source.
      @(posedge clk);
      #2;
      applyStimulus(2, 8'h80, 20);
      expQ.push_back(8'h02); expectRun(8'h80, 0, 9);
      present();
      repeat (11) @(posedge clk);
      #2;
      res = 1'b1;
      applyStimulus(0, 8'hA8, 2);
      expQ.push_back(8'h00); expectRun(8'hA8, 0, 2);
      expQ.push_back(8'h02); expectRun(8'h80, 10, 10);
      present();
      @(posedge clk);
      #2;
      res = 1'b0;
      @(negedge clk);
      checkOutput("mid reset s_tready", s_axis_tready, 4'b0000);
      checkOutput("mid reset m_tvalid", m_axis_tvalid, 1'b0);
      checkOutput("mid reset m_tdata", m_axis_tdata, 8'h00);
      checkOutput("mid reset grant_id", grant_id, 4'd0);
      checkOutput("mid reset busy", busy, 1'b0);
      checkOutput("mid reset m_ae", m_axis_almost_empty, 1'b1);
      waitDrain("reset recovery");

      @(negedge clk);
      checkOutput("final busy", busy, 1'b0);
      checkOutput("final m_ae", m_axis_almost_empty, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
